// File: rtl/keypad_if.sv
// keypad_if: key matrix and key-code bus between keypad_scanner and the timer
interface keypad_if;
  logic [3:0]  key_row;
  logic [2:0]  key_col;
  logic        key_clr;
  logic [11:0] key_data;
  modport master (input key_row, key_clr, output key_col, key_data);
  modport slave  (output key_row, key_clr, input key_col, key_data);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x3 matrix keypad scan, frame debounce and one-shot one-hot key code
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input logic      clk,
  input logic      rst,
  keypad_if.master kp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  typedef enum logic [1:0] {IDLE, PRESS, WAIT_REL} state_t;
  state_t          state, state_n;
  logic [DW-1:0]   div;
  logic [1:0]      col;
  logic [3:0]      snap0, snap1;
  logic [11:0]     prev, code, data_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            slot_end, frame, stable, press, release_k;
  assign slot_end  = div == DW'(SCAN_DIV - 1);
  assign frame     = slot_end && col == 2'd2;
  // frame code: columns 0/1 from snapshots, column 2 straight from the rows being captured now
  always_comb begin
    code = '0;
    for (int r = 0; r < 4; r++) begin
      code[r*3]   = snap0[r];
      code[r*3+1] = snap1[r];
      code[r*3+2] = ~kp.key_row[r];
    end
  end
  // debounce count: invalid frames zero it, a changed code restarts at 1, a repeat saturates
  always_comb begin
    cnt_n = !$onehot0(code) ? '0 : code != prev ? CW'(1) : cnt == CW'(DEBOUNCE_CNT) ? cnt : cnt + 1'b1;
  end
  assign stable    = cnt_n == CW'(DEBOUNCE_CNT);
  assign press     = frame && stable && $onehot(code);
  assign release_k = frame && stable && code == '0;
  // press/acknowledge/release state machine; key_clr acts on any cycle, release wins over clear
  always_comb begin
    state_n = state;
    data_n  = kp.key_data;
    case (state)
      IDLE:     if (press) begin state_n = PRESS; data_n = code; end
      PRESS:    if (release_k) begin state_n = IDLE; data_n = '0; end
                else if (kp.key_clr) begin state_n = WAIT_REL; data_n = '0; end
      WAIT_REL: if (release_k) state_n = IDLE;
      default:  begin state_n = IDLE; data_n = '0; end
    endcase
  end
  // scan divider, column rotation, row snapshots and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      div         <= '0;
      col         <= '0;
      snap0       <= '0;
      snap1       <= '0;
      prev        <= '0;
      cnt         <= '0;
      kp.key_col  <= 3'b110;
      kp.key_data <= '0;
    end else begin
      div <= slot_end ? '0 : div + 1'b1;
      if (slot_end) begin
        col        <= col == 2'd2 ? 2'd0 : col + 2'd1;
        kp.key_col <= {kp.key_col[1:0], kp.key_col[2]};
      end
      if (slot_end && col == 2'd0) snap0 <= ~kp.key_row;
      if (slot_end && col == 2'd1) snap1 <= ~kp.key_row;
      if (frame) begin
        prev <= code;
        cnt  <= cnt_n;
      end
      state       <= state_n;
      kp.key_data <= data_n;
    end
  end
endmodule
